// File: rtl/mem_stage_rsp_if.sv
// Handshake and payload bundle around the memory stage: execute-side input,
// write-back output, data-RAM response and the stall/bypass side buses.
`timescale 1ns/1ps
interface mem_stage_rsp_if #(
  parameter int IN_WD  = 73,
  parameter int OUT_WD = 70
);
  logic [IN_WD-1:0]  EXE_to_MEM_bus;
  logic              EXE_to_MEM_valid;
  logic              MEM_allow_in;
  logic [OUT_WD-1:0] MEM_to_WB_bus;
  logic              MEM_to_WB_valid;
  logic              WB_allow_in;
  logic [31:0]       data_ram_r_data;
  logic              data_ram_r_valid;
  logic [6:0]        MEM_to_ST_bus;
  logic [38:0]       MEM_to_BY_bus;

  // master is the surrounding pipeline and RAM; slave is the stage itself
  modport master (
    output EXE_to_MEM_bus, EXE_to_MEM_valid, WB_allow_in,
           data_ram_r_data, data_ram_r_valid,
    input  MEM_allow_in, MEM_to_WB_bus, MEM_to_WB_valid,
           MEM_to_ST_bus, MEM_to_BY_bus
  );

  modport slave (
    input  EXE_to_MEM_bus, EXE_to_MEM_valid, WB_allow_in,
           data_ram_r_data, data_ram_r_valid,
    output MEM_allow_in, MEM_to_WB_bus, MEM_to_WB_valid,
           MEM_to_ST_bus, MEM_to_BY_bus
  );
endinterface

// File: rtl/mem_stage_rsp.sv
// Memory pipeline stage: latches the execute bus, collects load data with a
// variable-latency RAM response, parks it while write-back is busy.
`timescale 1ns/1ps
module mem_stage_rsp #(
  parameter int IN_WD   = 73,
  parameter int OUT_WD  = 70,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_stage_rsp_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             resp_err,
  output logic             timeout_err
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state_reg;
  logic              mem_valid_reg;
  logic [IN_WD-1:0]  bus_reg;
  logic [31:0]       hold_reg;
  logic [WAIT_W-1:0] wait_reg;

  logic        is_load;
  logic        in_is_load;
  logic        data_ok;
  logic        allow_in;
  logic [31:0] load_data;
  logic [31:0] final_w_data;
  logic        unused_sel;

  assign is_load    = bus_reg[69];
  assign in_is_load = bus.EXE_to_MEM_bus[69];
  // write-data select field is carried but not consumed in this stage
  assign unused_sel = ^bus_reg[72:71];

  assign data_ok  = ~is_load | (state_reg == HOLD) |
                    ((state_reg == WAIT) & bus.data_ram_r_valid);
  assign allow_in = ~mem_valid_reg | (data_ok & bus.WB_allow_in);

  assign load_data    = (state_reg == HOLD) ? hold_reg : bus.data_ram_r_data;
  assign final_w_data = is_load ? load_data : bus_reg[36:5];

  assign bus.MEM_allow_in    = allow_in;
  assign bus.MEM_to_WB_valid = mem_valid_reg & data_ok;
  assign bus.MEM_to_WB_bus   = {bus_reg[70], bus_reg[68:37], final_w_data, bus_reg[4:0]};
  assign bus.MEM_to_ST_bus   = {mem_valid_reg, mem_valid_reg & is_load & ~data_ok, bus_reg[4:0]};
  assign bus.MEM_to_BY_bus   = {bus_reg[70], mem_valid_reg & data_ok, bus_reg[4:0], final_w_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      mem_valid_reg <= 1'b0;
      bus_reg       <= '0;
      hold_reg      <= '0;
      wait_reg      <= '0;
      stall_cnt     <= '0;
      resp_err      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      // a response is only legal while a load is waiting for it
      if ((state_reg != WAIT) && bus.data_ram_r_valid)
        resp_err <= 1'b1;

      if (allow_in) begin
        mem_valid_reg <= bus.EXE_to_MEM_valid;
        if (bus.EXE_to_MEM_valid)
          bus_reg <= bus.EXE_to_MEM_bus;
        state_reg <= (bus.EXE_to_MEM_valid && in_is_load) ? WAIT : IDLE;
        wait_reg  <= '0;
      end else if (state_reg == WAIT) begin
        if (!bus.data_ram_r_valid) begin
          if (stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
          if (wait_reg != WAIT_W'(TIMEOUT))
            wait_reg <= wait_reg + WAIT_W'(1);
          if (wait_reg == WAIT_W'(TIMEOUT - 1))
            timeout_err <= 1'b1;
        end else begin
          // data arrived but write-back is busy: park it
          hold_reg  <= bus.data_ram_r_data;
          state_reg <= HOLD;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_rsp.sv
// Bench for mem_stage_rsp: directed scenarios then random traffic, checked
// each cycle against an instruction-level model of the stage.
`timescale 1ns/1ps
module tb_mem_stage_rsp;
  localparam int IN_WD = 73, OUT_WD = 70, TIMEOUT = 16, CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] stall_cnt;
  logic resp_err, timeout_err;

  always #5 clk = ~clk;

  mem_stage_rsp_if #(.IN_WD(IN_WD), .OUT_WD(OUT_WD)) bus_if ();

  mem_stage_rsp #(.IN_WD(IN_WD), .OUT_WD(OUT_WD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave),
    .stall_cnt(stall_cnt), .resp_err(resp_err), .timeout_err(timeout_err)
  );

  int checks = 0, passed = 0, failed = 0;

  // model: the instruction currently in the stage and what it knows about its data
  bit m_valid, m_load, m_wen, m_got, m_resp, m_tmo;
  logic [31:0] m_pc, m_rfd, m_data;
  logic [4:0] m_addr;
  int m_waited, m_stall;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_WD-1:0] mk(bit ld, bit wen, logic [31:0] pc, logic [31:0] rfd, logic [4:0] a);
    logic [1:0] sel;
    sel = 2'($urandom_range(0, 3));
    return {sel, wen, ld, pc, rfd, a};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_load = 0; m_wen = 0; m_got = 0; m_resp = 0; m_tmo = 0;
    m_pc = 0; m_rfd = 0; m_data = 0; m_addr = 0; m_waited = 0; m_stall = 0;
  endtask

  function automatic bit waiting();
    return m_valid && m_load && !m_got;
  endfunction

  function automatic bit data_ok_now();
    return !m_load || m_got || (waiting() && bus_if.data_ram_r_valid);
  endfunction

  task automatic check_cycle();
    bit dok, eallow, ewbv;
    logic [31:0] fin;
    dok    = data_ok_now();
    eallow = !m_valid || (dok && bus_if.WB_allow_in);
    ewbv   = m_valid && dok;
    fin    = m_load ? (m_got ? m_data : bus_if.data_ram_r_data) : m_rfd;
    chk("allow_in", bus_if.MEM_allow_in, eallow);
    chk("wb_valid", bus_if.MEM_to_WB_valid, ewbv);
    if (ewbv) begin
      chk("wb_bus", bus_if.MEM_to_WB_bus, {m_wen, m_pc, fin, m_addr});
      chk("by_bus", bus_if.MEM_to_BY_bus, {m_wen, 1'b1, m_addr, fin});
    end else
      chk("by_fwd", bus_if.MEM_to_BY_bus[37], 1'b0);
    chk("st_bus", bus_if.MEM_to_ST_bus, {m_valid, m_valid && m_load && !dok, m_addr});
    chk("stall_cnt", stall_cnt, m_stall[CNT_W-1:0]);
    chk("resp_err", resp_err, m_resp);
    chk("timeout_err", timeout_err, m_tmo);
  endtask

  task automatic drive(bit ev, logic [IN_WD-1:0] eb, bit wb, bit rv, logic [31:0] rd);
    @(negedge clk);
    bus_if.EXE_to_MEM_valid = ev;
    bus_if.EXE_to_MEM_bus   = eb;
    bus_if.WB_allow_in      = wb;
    bus_if.data_ram_r_valid = rv;
    bus_if.data_ram_r_data  = rd;
    #1;
  endtask

  task automatic tick();
    bit w, allow, ev, rv;
    logic [IN_WD-1:0] eb;
    logic [31:0] rd;
    w     = waiting();
    allow = !m_valid || (data_ok_now() && bus_if.WB_allow_in);
    ev = bus_if.EXE_to_MEM_valid; eb = bus_if.EXE_to_MEM_bus;
    rv = bus_if.data_ram_r_valid; rd = bus_if.data_ram_r_data;
    @(posedge clk);
    if (rv && !w) m_resp = 1;
    if (allow) begin
      m_got = 0; m_waited = 0; m_valid = ev;
      if (ev) begin
        m_load = eb[69]; m_wen = eb[70]; m_pc = eb[68:37]; m_rfd = eb[36:5]; m_addr = eb[4:0];
      end
    end else if (w) begin
      if (!rv) begin
        if (m_stall < 65535) m_stall++;
        m_waited++;
        if (m_waited == TIMEOUT) m_tmo = 1;
      end else begin
        m_got = 1; m_data = rd;
      end
    end
  endtask

  task automatic cyc(bit ev, logic [IN_WD-1:0] eb, bit wb, bit rv, logic [31:0] rd);
    drive(ev, eb, wb, rv, rd);
    check_cycle();
    tick();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 0;
    bus_if.EXE_to_MEM_valid = 0; bus_if.EXE_to_MEM_bus = '0; bus_if.WB_allow_in = 0;
    bus_if.data_ram_r_valid = 0; bus_if.data_ram_r_data = '0;
    #1;
    model_reset();
    check_cycle();
    chk("rst_allow", bus_if.MEM_allow_in, 1'b1);
    chk("rst_wb_bus", bus_if.MEM_to_WB_bus, '0);
    @(negedge clk);
    reset = 1;
    #1;
    check_cycle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_WD-1:0] ld, add;
    apply_reset();

    // ALU op passes straight through
    cyc(1, mk(0, 1, 32'h100, 32'h1234_5678, 5'd5), 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    check_cycle();
    chk("alu_valid", bus_if.MEM_to_WB_valid, 1'b1);
    chk("alu_data", bus_if.MEM_to_WB_bus[36:5], 32'h1234_5678);
    tick();

    // load answered in its first memory cycle
    cyc(1, mk(1, 1, 32'h104, 32'h0, 5'd7), 1, 0, 0);
    drive(0, '0, 1, 1, 32'hDEAD_BEEF);
    check_cycle();
    chk("ld0_data", bus_if.MEM_to_WB_bus[36:5], 32'hDEAD_BEEF);
    tick();
    cyc(0, '0, 1, 0, 0);

    // load answered after three stall cycles
    cyc(1, mk(1, 1, 32'h108, 32'h0, 5'd9), 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 0, $urandom);
      check_cycle();
      chk("ld3_pending", bus_if.MEM_to_ST_bus[5], 1'b1);
      tick();
    end
    drive(0, '0, 1, 1, 32'hCAFE_F00D);
    check_cycle();
    chk("ld3_stall", stall_cnt, 16'd3);
    chk("ld3_data", bus_if.MEM_to_WB_bus[36:5], 32'hCAFE_F00D);
    tick();

    // data parked while write-back is busy
    cyc(1, mk(1, 0, 32'h10C, 32'h0, 5'd11), 1, 0, 0);
    cyc(0, '0, 0, 1, 32'hA5A5_A5A5);
    cyc(0, '0, 0, 0, 32'h0);
    drive(0, '0, 1, 0, 32'h0);
    check_cycle();
    chk("hold_data", bus_if.MEM_to_WB_bus[36:5], 32'hA5A5_A5A5);
    tick();

    // load followed by add with no bubble
    ld  = mk(1, 1, 32'h110, 32'h0, 5'd12);
    add = mk(0, 1, 32'h114, 32'h0BAD_F00D, 5'd13);
    cyc(1, ld, 1, 0, 0);
    drive(1, add, 1, 1, 32'h1111_2222);
    check_cycle();
    chk("b2b_accept", bus_if.MEM_allow_in, 1'b1);
    tick();
    drive(0, '0, 1, 0, 0);
    check_cycle();
    chk("b2b_pending", bus_if.MEM_to_ST_bus[5], 1'b0);
    chk("b2b_data", bus_if.MEM_to_WB_bus[36:5], 32'h0BAD_F00D);
    chk("b2b_resp", resp_err, 1'b0);
    tick();

    // timeout, then reset mid-wait, then a stray response
    cyc(1, mk(1, 1, 32'h118, 32'h0, 5'd14), 1, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) cyc(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    check_cycle();
    chk("tmo_set", timeout_err, 1'b1);
    apply_reset();
    chk("rst_tmo", timeout_err, 1'b0);
    cyc(0, '0, 1, 1, 32'h5555_AAAA);
    drive(0, '0, 1, 0, 0);
    check_cycle();
    chk("stray_resp", resp_err, 1'b1);
    tick();

    // random traffic with well-behaved RAM timing
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      bit ev, wb, rv;
      ev = ($urandom_range(0, 3) != 0);
      wb = ($urandom_range(0, 3) != 0);
      rv = waiting() && ($urandom_range(0, 2) == 0);
      cyc(ev, mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 5'($urandom_range(0, 31))), wb, rv, $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
